// File: rtl/packet_ejector.sv
// packet_ejector: NoC local-port sink. Flit FIFO with credit return, packet reassembly and checking.
// Optional tail checksum check is compiled in when EJECTOR_CHECKSUM_EN is defined.
`ifndef BUFFERSIZE_WIDTH
`define BUFFERSIZE_WIDTH $clog2(P_DEPTH + 1)
`endif

module packet_ejector #(
  parameter int unsigned P_LOCAL_ID = 0,
  parameter int unsigned P_DEPTH    = 4,
  parameter int unsigned P_ID_W     = 8,
  parameter int unsigned P_SRC_W    = 4,
  parameter int unsigned P_DST_W    = 4,
  parameter int unsigned P_MAX_BODY = 5
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           data_valid,
  input  logic [33:0]                    data_in,
  output logic [`BUFFERSIZE_WIDTH-1:0]   credit_feedback,
  input  logic                           consume_ready,
  output logic                           pkt_done,
  output logic [P_ID_W-1:0]              pkt_id,
  output logic [P_SRC_W-1:0]             pkt_src,
  output logic [3:0]                     pkt_len,
  output logic [3:0]                     pkt_err,
  output logic                           overflow,
  output logic [15:0]                    pkt_count
);

  localparam int unsigned FLIT_W = 34;
  localparam int unsigned PTR_W  = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(P_DEPTH + 1);
  localparam int unsigned CRED_W = `BUFFERSIZE_WIDTH;
  localparam int unsigned PL_W   = 28 - P_ID_W;

  localparam logic [1:0] T_HEAD = 2'b10;
  localparam logic [1:0] T_BODY = 2'b11;
  localparam logic [1:0] T_TAIL = 2'b01;

  typedef enum logic {S_HEAD, S_BODY} state_e;

  // FIFO storage and bookkeeping
  logic [FLIT_W-1:0] mem_q [P_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CRED_W-1:0] credit_q, credit_d;
  logic              overflow_q, overflow_d;
  logic              full_c, push_c, pop_c;

  // Packet checker state and registered report
  state_e            state_q, state_d;
  logic [P_ID_W-1:0] id_q, id_d;
  logic [P_SRC_W-1:0] src_q, src_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        acc_q, acc_d;
  logic              done_q, done_d;
  logic [P_ID_W-1:0] oid_q, oid_d;
  logic [P_SRC_W-1:0] osrc_q, osrc_d;
  logic [3:0]        olen_q, olen_d;
  logic [3:0]        oerr_q, oerr_d;
  logic [15:0]       pcnt_q, pcnt_d;

  logic [FLIT_W-1:0]  flit_c;
  logic [1:0]         ftype_c;
  logic [P_ID_W-1:0]  fid_c;
  logic [P_SRC_W-1:0] fsrc_c;
  logic [P_DST_W-1:0] fdst_c;
  logic [PL_W-1:0]    fpl_c;
  logic               dst_bad_c, id_bad_c, cs_bad_c;
  logic [3:0]         cnt_inc_c;
  logic [4:0]         len_tail_c, len_abort_c;
  logic               unused_flags;

  assign full_c = (count_q == CNT_W'(P_DEPTH));
  assign push_c = data_valid && !full_c;
  assign pop_c  = (count_q != '0) && consume_ready;

  assign flit_c  = mem_q[rd_ptr_q];
  assign ftype_c = flit_c[33:32];
  assign fid_c   = flit_c[P_ID_W+3:4];
  assign fsrc_c  = flit_c[31 -: P_SRC_W];
  assign fdst_c  = flit_c[31-P_SRC_W -: P_DST_W];
  assign fpl_c   = flit_c[31:P_ID_W+4];
  assign unused_flags = ^flit_c[3:0];

  assign dst_bad_c   = (fdst_c != P_DST_W'(P_LOCAL_ID));
  assign id_bad_c    = (fid_c != id_q);
  assign cnt_inc_c   = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;
  assign len_tail_c  = {1'b0, cnt_q} + 5'd2;
  assign len_abort_c = {1'b0, cnt_q} + 5'd1;

`ifdef EJECTOR_CHECKSUM_EN
  // Field is zero-extended so any set bit above the low 20 also flags an error
  assign cs_bad_c = (32'(fpl_c) != 32'h000F_0F0F);
`else
  assign cs_bad_c = 1'b0;
`endif

  always_comb begin
    count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    wr_ptr_d   = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    credit_d   = CRED_W'(P_DEPTH) - CRED_W'(count_d);
    overflow_d = overflow_q | (data_valid & full_c);
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    oid_d   = oid_q;
    osrc_d  = osrc_q;
    olen_d  = olen_q;
    oerr_d  = oerr_q;
    pcnt_d  = pcnt_q;

    if (pop_c) begin
      case (state_q)
        S_HEAD: begin
          if (ftype_c == T_HEAD) begin
            id_d    = fid_c;
            src_d   = fsrc_c;
            cnt_d   = 4'd0;
            acc_d   = {3'b000, dst_bad_c};
            state_d = S_BODY;
          end else begin
            done_d = 1'b1;
            oid_d  = fid_c;
            osrc_d = '0;
            olen_d = 4'd1;
            oerr_d = 4'b0100;
          end
        end
        S_BODY: begin
          case (ftype_c)
            T_BODY: begin
              cnt_d    = cnt_inc_c;
              acc_d[2] = acc_q[2] | (fpl_c != PL_W'(cnt_inc_c))
                         | (32'(cnt_inc_c) > P_MAX_BODY);
              acc_d[1] = acc_q[1] | id_bad_c;
            end
            T_TAIL: begin
              done_d  = 1'b1;
              oid_d   = id_q;
              osrc_d  = src_q;
              olen_d  = len_tail_c[4] ? 4'hF : len_tail_c[3:0];
              oerr_d  = acc_q | {cs_bad_c, 1'b0, id_bad_c, 1'b0};
              state_d = S_HEAD;
            end
            T_HEAD: begin
              // Abort the open packet, then restart on this head
              done_d = 1'b1;
              oid_d  = id_q;
              osrc_d = src_q;
              olen_d = len_abort_c[4] ? 4'hF : len_abort_c[3:0];
              oerr_d = acc_q | 4'b0100;
              id_d   = fid_c;
              src_d  = fsrc_c;
              cnt_d  = 4'd0;
              acc_d  = {3'b000, dst_bad_c};
            end
            default: acc_d[2] = 1'b1;
          endcase
        end
        default: state_d = S_HEAD;
      endcase
    end

    if (done_d && (oerr_d == 4'b0000) && (pcnt_q != 16'hFFFF)) begin
      pcnt_d = pcnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      credit_q   <= CRED_W'(P_DEPTH);
      overflow_q <= 1'b0;
      state_q    <= S_HEAD;
      id_q       <= '0;
      src_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      done_q     <= 1'b0;
      oid_q      <= '0;
      osrc_q     <= '0;
      olen_q     <= '0;
      oerr_q     <= '0;
      pcnt_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      id_q       <= id_d;
      src_q      <= src_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      done_q     <= done_d;
      oid_q      <= oid_d;
      osrc_q     <= osrc_d;
      olen_q     <= olen_d;
      oerr_q     <= oerr_d;
      pcnt_q     <= pcnt_d;
    end
  end

  assign credit_feedback = credit_q;
  assign overflow        = overflow_q;
  assign pkt_done        = done_q;
  assign pkt_id          = oid_q;
  assign pkt_src         = osrc_q;
  assign pkt_len         = olen_q;
  assign pkt_err         = oerr_q;
  assign pkt_count       = pcnt_q;

endmodule

// File: tb/tb_packet_ejector.sv
// Scoreboard bench for packet_ejector: stimulus queues expected completions, a monitor checks each pkt_done.
module tb_packet_ejector;

  logic        CLK;
  logic        RST;
  logic        data_valid;
  logic [33:0] data_in;
  logic [2:0]  credit_feedback;
  logic        consume_ready;
  logic        pkt_done;
  logic [7:0]  pkt_id;
  logic [3:0]  pkt_src;
  logic [3:0]  pkt_len;
  logic [3:0]  pkt_err;
  logic        overflow;
  logic [15:0] pkt_count;

  typedef struct packed {
    logic [7:0]  id;
    logic [3:0]  src;
    logic [3:0]  len;
    logic [3:0]  err;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_cnt  = 16'd0;

  packet_ejector #(
    .P_LOCAL_ID(0), .P_DEPTH(4), .P_ID_W(8),
    .P_SRC_W(4), .P_DST_W(4), .P_MAX_BODY(5)
  ) dut (
    .CLK(CLK), .RST(RST), .data_valid(data_valid), .data_in(data_in),
    .credit_feedback(credit_feedback), .consume_ready(consume_ready),
    .pkt_done(pkt_done), .pkt_id(pkt_id), .pkt_src(pkt_src), .pkt_len(pkt_len),
    .pkt_err(pkt_err), .overflow(overflow), .pkt_count(pkt_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [33:0] head(input logic [3:0] src, input logic [3:0] dst, input logic [7:0] id);
    return {2'b10, src, dst, 12'h000, id, 4'h0};
  endfunction

  function automatic logic [33:0] body(input logic [7:0] id, input logic [19:0] idx);
    return {2'b11, idx, id, 4'h0};
  endfunction

  function automatic logic [33:0] tail(input logic [7:0] id, input logic [19:0] cs);
    return {2'b01, cs, id, 4'h0};
  endfunction

  task automatic expect_pkt(input logic [7:0] id, input logic [3:0] src,
                            input logic [3:0] len, input logic [3:0] err);
    exp_t e;
    if (err == 4'b0000) exp_cnt = exp_cnt + 16'd1;
    e = '{id: id, src: src, len: len, err: err, cnt: exp_cnt};
    sb_q.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge and are held through the next one
  task automatic send(input logic [33:0] f);
    data_in    = f;
    data_valid = 1'b1;
    @(posedge CLK); #1;
    data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  always @(negedge CLK) begin
    if (RST && pkt_done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_pkt_done", 64'(pkt_id), 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("pkt_report{id,src,len,err,count}",
            64'({pkt_id, pkt_src, pkt_len, pkt_err, pkt_count}), 64'(e));
      end
    end
  end

  initial begin
    int guard;
    RST           = 1'b0;
    data_valid    = 1'b0;
    data_in       = '0;
    consume_ready = 1'b1;
    #12;
    chk("reset_credit",    64'(credit_feedback), 64'd4);
    chk("reset_pkt_count", 64'(pkt_count),       64'd0);
    chk("reset_pkt_done",  64'(pkt_done),        64'd0);
    chk("reset_overflow",  64'(overflow),        64'd0);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;

    // Clean packet: src 2, id 7, three bodies
    expect_pkt(8'd7, 4'd2, 4'd5, 4'b0000);
    send(head(4'd2, 4'd0, 8'd7));
    send(body(8'd7, 20'd1));
    send(body(8'd7, 20'd2));
    send(body(8'd7, 20'd3));
    send(tail(8'd7, 20'hF0F0F));
    idle(4);
    chk("pkt_count_after_first", 64'(pkt_count), 64'd1);
    chk("credit_idle", 64'(credit_feedback), 64'd4);

    // Backpressure and overflow
    consume_ready = 1'b0;
    expect_pkt(8'd3, 4'd1, 4'd4, 4'b0000);
    send(head(4'd1, 4'd0, 8'd3));
    chk("credit_bp1", 64'(credit_feedback), 64'd3);
    send(body(8'd3, 20'd1));
    chk("credit_bp2", 64'(credit_feedback), 64'd2);
    send(body(8'd3, 20'd2));
    chk("credit_bp3", 64'(credit_feedback), 64'd1);
    send(tail(8'd3, 20'hF0F0F));
    chk("credit_bp4", 64'(credit_feedback), 64'd0);
    chk("overflow_before_drop", 64'(overflow), 64'd0);
    send(body(8'd3, 20'd9));
    chk("overflow_after_drop", 64'(overflow), 64'd1);
    chk("credit_full", 64'(credit_feedback), 64'd0);
    consume_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge CLK); #1;
      chk($sformatf("credit_drain%0d", i), 64'(credit_feedback), 64'(i));
    end
    idle(3);

    // Wrong destination
    expect_pkt(8'd9, 4'd5, 4'd2, 4'b0001);
    send(head(4'd5, 4'd3, 8'd9));
    send(tail(8'd9, 20'hF0F0F));

    // Body while waiting for a head
    expect_pkt(8'd4, 4'd0, 4'd1, 4'b0100);
    send(body(8'd4, 20'd1));

    // Head followed by head: abort, then the second packet completes
    expect_pkt(8'd10, 4'd1, 4'd1, 4'b0100);
    expect_pkt(8'd11, 4'd6, 4'd3, 4'b0000);
    send(head(4'd1, 4'd0, 8'd10));
    send(head(4'd6, 4'd0, 8'd11));
    send(body(8'd11, 20'd1));
    send(tail(8'd11, 20'hF0F0F));

    // Body with foreign id
    expect_pkt(8'd7, 4'd2, 4'd3, 4'b0010);
    send(head(4'd2, 4'd0, 8'd7));
    send(body(8'd8, 20'd1));
    send(tail(8'd7, 20'hF0F0F));

    // Six bodies exceeds the maximum of five
    expect_pkt(8'd12, 4'd3, 4'd8, 4'b0100);
    send(head(4'd3, 4'd0, 8'd12));
    for (int b = 1; b <= 6; b++) send(body(8'd12, 20'(b)));
    send(tail(8'd12, 20'hF0F0F));

    // Bad checksum
`ifdef EJECTOR_CHECKSUM_EN
    expect_pkt(8'd13, 4'd4, 4'd3, 4'b1000);
`else
    expect_pkt(8'd13, 4'd4, 4'd3, 4'b0000);
`endif
    send(head(4'd4, 4'd0, 8'd13));
    send(body(8'd13, 20'd1));
    send(tail(8'd13, 20'hF0F0E));

    // Clean packet after errors
    expect_pkt(8'd14, 4'd1, 4'd2, 4'b0000);
    send(head(4'd1, 4'd0, 8'd14));
    send(tail(8'd14, 20'hF0F0F));

    guard = 0;
    while (sb_q.size() != 0 && guard < 100) begin
      @(posedge CLK); #1;
      guard++;
    end
    idle(3);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    chk("overflow_sticky", 64'(overflow), 64'd1);
    chk("final_pkt_count", 64'(pkt_count), 64'(exp_cnt));
    chk("final_credit", 64'(credit_feedback), 64'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/packet_ejector.md
Name: packet_ejector

Overview:
- Local-port sink for a NoC router. Consumes the flit stream that the router's local output delivers from remote packet injectors.
- Buffers incoming flits in a small FIFO and returns free-slot credits to the router.
- Reassembles and checks each head/body/tail packet, then reports per-packet completion, identity, length and error status.
- Together with the packet injector it closes the traffic-generation loop on each tile.

Parameters:
- P_LOCAL_ID, 0: node ID of this ejector; compared against the head-flit destination.
- P_DEPTH, 4: FIFO depth in flits; a power of two, minimum 2.
- P_ID_W, 8: packet ID field width.
- P_SRC_W, 4: head source field width.
- P_DST_W, 4: head destination field width.
- P_MAX_BODY, 5: maximum number of body flits per packet.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-low reset.
- data_valid  in  1  flit present on data_in this cycle.
- data_in  in  34  flit.
- credit_feedback  out  `BUFFERSIZE_WIDTH  free FIFO slots, registered.
- consume_ready  in  1  downstream allows one FIFO pop per cycle.
- pkt_done  out  1  one-cycle pulse when a packet completes or is aborted.
- pkt_id  out  P_ID_W  ID of the completed packet.
- pkt_src  out  P_SRC_W  source of the completed packet.
- pkt_len  out  4  total flits, including head and tail.
- pkt_err  out  4  error flags; valid while pkt_done is high.
- overflow  out  1  sticky; set when a flit is dropped because the FIFO is full.
- pkt_count  out  16  count of error-free packets.

Behaviour:
- Flit layout:
  - type [33:32]: head 2'b10, body 2'b11, tail 2'b01.
  - flags [3:0].
  - id [P_ID_W+3:4].
  - head: src [31:32-P_SRC_W], dst directly below src.
  - body: payload [31:P_ID_W+4] holds the body index, starting at 1.
  - tail: checksum [31:P_ID_W+4].
- Reset (RST=0, asynchronous):
  - FIFO is emptied.
  - credit_feedback=P_DEPTH.
  - pkt_done=0, pkt_id=0, pkt_src=0, pkt_len=0, pkt_err=0.
  - overflow=0, pkt_count=0.
  - FSM goes to S_HEAD.
  - Reset mid-packet discards all partial state.
- FIFO push:
  - On a clock edge with data_valid=1 and count<P_DEPTH, the flit is written.
  - If count==P_DEPTH, the flit is dropped and overflow is set, even if a pop happens on the same edge.
- FIFO pop: on an edge with count>0 and consume_ready=1, the head entry is passed to the checker.
- Simultaneous push and pop: count is unchanged.
- credit_feedback is P_DEPTH minus the registered count. It updates on the edge after the push or pop.
- Pointers wrap modulo P_DEPTH.
- FSM state S_HEAD:
  - A head pop latches id, src and dst. It sets err[0] if dst != P_LOCAL_ID, clears the body counter, and moves to S_BODY.
  - A non-head pop is discarded, with pkt_done=1, pkt_len=1 and err[2]=1. State stays S_HEAD.
- FSM state S_BODY, body pop:
  - Increments the body counter.
  - Sets err[2] if payload != counter or counter > P_MAX_BODY.
  - Sets err[1] if id differs from the latched id.
- FSM state S_BODY, tail pop:
  - Performs the id check.
  - Sets pkt_done, pkt_len = counter+2 and pkt_err.
  - Moves to S_HEAD.
- FSM state S_BODY, head pop:
  - Aborts the current packet: pkt_done=1, pkt_len = counter+1, err[2]=1.
  - Then treats this head as the start of a new packet and stays in S_BODY.
- Body counter saturates at 15.
- Latency: a tail presented at edge k, with an empty FIFO and consume_ready=1, is popped at edge k+1. pkt_done is high in the cycle after edge k+1.
- pkt_done is high for exactly one cycle per completion.
- pkt_id, pkt_src, pkt_len and pkt_err hold their values until the next completion.
- pkt_count increments on each completion with pkt_err==0 and saturates at 16'hFFFF.

Optional Feature:
- Macro EJECTOR_CHECKSUM_EN.
- Defined: on a tail flit, err[3] is set if the checksum field's low 20 bits != 20'hF0F0F, or any higher bit is nonzero.
- Not defined: the checksum field is ignored and err[3] is tied to 0.

Test Plan:
- Reset: RST low → credit_feedback=4, pkt_count=0. Then a packet from node 2, id=7, dst=0, with 3 bodies (payloads 1,2,3) and consume_ready=1 → single pkt_done, pkt_len=5, pkt_src=2, pkt_id=7, pkt_err=0, pkt_count=1.
- Backpressure: consume_ready=0, push 4 flits → credit_feedback reaches 0. A 5th flit → dropped, overflow=1. Then consume_ready=1 → credits return to 4 over 4 cycles.
- Bad destination: head dst=3 at P_LOCAL_ID=0, followed by a tail → pkt_err=4'b0001, pkt_count unchanged.
- Sequence errors: a body flit while in S_HEAD → pkt_done, pkt_len=1, err[2]. A head followed by another head → abort with pkt_len=1, err[2], then the second packet completes cleanly.
- Id and length: body id=8 inside an id=7 packet → err[1]. Six bodies → err[2], pkt_len=8.
- Checksum (EJECTOR_CHECKSUM_EN defined): tail checksum 20'hF0F0E → err[3]=1. Same stimulus with the macro undefined → pkt_err=0.
